// File: rtl/rockets_pkg.sv
// rtl/rockets_pkg.sv - shared types and constants for the rocket slot logic
// Purpose: coordinate width, fixed-point split, field borders and slot states.
package rockets_pkg;

    localparam int COORD_W       = 11;
    localparam int FRAC_BITS     = 6;
    localparam int TOP_BORDER    = 0;
    localparam int BOTTOM_BORDER = 464;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        OUT  = 2'd2
    } slot_state_t;

    typedef logic signed [COORD_W-1:0] coord_t;

endpackage

// File: rtl/rocket_slot.sv
// rtl/rocket_slot.sv - one rocket slot: arm capture, vertical integrator, exit flag
// Purpose: arms on a rising isActive, moves Y once per frame in fixed point,
//          flags when the rocket leaves the field, drops when isActive falls.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   startOfFrame       one-cycle frame pulse
//   isActive           arm level for this slot
//   initialX/Y/Speed   launch bus, sampled on the rising cycle of isActive
//   rocketTLX/TLY      current top-left position (integer pixels)
//   inFlight           slot is FLY or OUT
//   reachedBorder      exit flag gated by isActive
module rocket_slot
    import rockets_pkg::*;
#(
    parameter int P_FRAC   = FRAC_BITS,
    parameter int P_TOP    = TOP_BORDER,
    parameter int P_BOTTOM = BOTTOM_BORDER
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   startOfFrame,
    input  logic   isActive,
    input  coord_t initialX,
    input  coord_t initialY,
    input  coord_t initialSpeed,
    output coord_t rocketTLX,
    output coord_t rocketTLY,
    output logic   inFlight,
    output logic   reachedBorder
);

    localparam int YF_W = COORD_W + P_FRAC;

    slot_state_t            r_state, w_state_next;
    logic                   r_act_d;
    logic                   r_flag, w_flag_next;
    coord_t                 r_x, w_x_next;
    coord_t                 r_spd, w_spd_next;
    logic signed [YF_W-1:0] r_yfix, w_yfix_next, w_yfix_step;
    coord_t                 w_y_step;
    logic                   w_rise;

    assign w_rise      = isActive & ~r_act_d;
    assign w_yfix_step = r_yfix + {{P_FRAC{r_spd[COORD_W-1]}}, r_spd};
    // Integer part of the stepped position; the exit test looks at where the
    // rocket will be after this frame, not where it was.
    assign w_y_step    = w_yfix_step[YF_W-1:P_FRAC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_act_d <= 1'b0;
            r_flag  <= 1'b0;
            r_x     <= '0;
            r_spd   <= '0;
            r_yfix  <= '0;
        end else begin
            r_state <= w_state_next;
            r_act_d <= isActive;
            r_flag  <= w_flag_next;
            r_x     <= w_x_next;
            r_spd   <= w_spd_next;
            r_yfix  <= w_yfix_next;
        end
    end

    // Priority: rise (capture) over fall over movement. A rise with a frame
    // pulse therefore captures without stepping, and a fall with a frame
    // pulse drops the slot without stepping.
    always_comb begin
        w_state_next = r_state;
        w_flag_next  = r_flag;
        w_x_next     = r_x;
        w_spd_next   = r_spd;
        w_yfix_next  = r_yfix;
        if (w_rise) begin
            w_x_next     = initialX;
            w_yfix_next  = {initialY, {P_FRAC{1'b0}}};
            w_spd_next   = initialSpeed;
            w_state_next = FLY;
            w_flag_next  = 1'b0;
        end else if ((r_state != IDLE) && !isActive) begin
            w_state_next = IDLE;
            w_flag_next  = 1'b0;
        end else if ((r_state == FLY) && startOfFrame) begin
            w_yfix_next = w_yfix_step;
            if (((r_spd < 0) && (w_y_step <= coord_t'(P_TOP))) ||
                ((r_spd > 0) && (w_y_step >= coord_t'(P_BOTTOM)))) begin
                w_state_next = OUT;
                w_flag_next  = 1'b1;
            end
        end
    end

    assign rocketTLX     = r_x;
    assign rocketTLY     = r_yfix[YF_W-1:P_FRAC];
    assign inFlight      = (r_state != IDLE);
    // Gated so the flag disappears in the same cycle the controller clears
    // isActive, preventing its XOR-clear from re-arming the slot.
    assign reachedBorder = r_flag & isActive;

endmodule

// File: rtl/rocket_slots_engine.sv
// rtl/rocket_slots_engine.sv - NUM_SLOTS rocket slots sharing one launch bus
// Purpose: splits the per-slot arm bits, fans out the launch bus and
//          concatenates per-slot outputs (slot i at [11*i +: 11]).
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   startOfFrame                     one-cycle frame pulse
//   isActive[NUM_SLOTS]              per-slot arm levels
//   initialX/initialY/initialSpeed   shared signed launch bus
//   rocketTLX/rocketTLY              packed per-slot positions
//   inFlight/reachedBorder           per-slot status
module rocket_slots_engine
    import rockets_pkg::*;
#(
    parameter int NUM_SLOTS     = 3,
    parameter int FRAC_BITS     = rockets_pkg::FRAC_BITS,
    parameter int TOP_BORDER    = rockets_pkg::TOP_BORDER,
    parameter int BOTTOM_BORDER = rockets_pkg::BOTTOM_BORDER
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           startOfFrame,
    input  logic [NUM_SLOTS-1:0]           isActive,
    input  logic signed [COORD_W-1:0]      initialX,
    input  logic signed [COORD_W-1:0]      initialY,
    input  logic signed [COORD_W-1:0]      initialSpeed,
    output logic [NUM_SLOTS*COORD_W-1:0]   rocketTLX,
    output logic [NUM_SLOTS*COORD_W-1:0]   rocketTLY,
    output logic [NUM_SLOTS-1:0]           inFlight,
    output logic [NUM_SLOTS-1:0]           reachedBorder
);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        rocket_slot #(
            .P_FRAC   (FRAC_BITS),
            .P_TOP    (TOP_BORDER),
            .P_BOTTOM (BOTTOM_BORDER)
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .startOfFrame  (startOfFrame),
            .isActive      (isActive[g]),
            .initialX      (initialX),
            .initialY      (initialY),
            .initialSpeed  (initialSpeed),
            .rocketTLX     (rocketTLX[COORD_W*g +: COORD_W]),
            .rocketTLY     (rocketTLY[COORD_W*g +: COORD_W]),
            .inFlight      (inFlight[g]),
            .reachedBorder (reachedBorder[g])
        );
    end

endmodule

// File: tb/tb_rocket_slots_engine.sv
// tb/tb_rocket_slots_engine.sv - self-checking bench for rocket_slots_engine
module tb_rocket_slots_engine;

    logic               clk = 1'b0;
    logic               reset;
    logic               sof;
    logic [2:0]         act;
    logic signed [10:0] ix, iy, isp;
    logic [32:0]        tlx, tly;
    logic [2:0]         infl, rb;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-slot mode (0 idle, 1 flying, 2 exited), position
    // kept as an integer count of 1/64 pixels.
    int m_state[3];
    int m_x[3];
    int m_yf[3];
    int m_spd[3];
    bit m_prev[3];

    typedef struct {
        bit         sof;
        logic [2:0] act;
        int         x, y, sp;
        logic [2:0] e_infl;
        int         e_tlx0, e_tly0;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    rocket_slots_engine dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (sof),
        .isActive      (act),
        .initialX      (ix),
        .initialY      (iy),
        .initialSpeed  (isp),
        .rocketTLX     (tlx),
        .rocketTLY     (tly),
        .inFlight      (infl),
        .reachedBorder (rb)
    );

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_state[i] = 0; m_x[i] = 0; m_yf[i] = 0; m_spd[i] = 0; m_prev[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit a_i;
            int y;
            a_i = act[i];
            if (a_i && !m_prev[i]) begin
                m_x[i]     = int'(ix);
                m_yf[i]    = int'(iy) * 64;
                m_spd[i]   = int'(isp);
                m_state[i] = 1;
            end else if (m_state[i] != 0 && !a_i) begin
                m_state[i] = 0;
            end else if (m_state[i] == 1 && sof) begin
                m_yf[i] = m_yf[i] + m_spd[i];
                y = m_yf[i] >>> 6;
                if ((m_spd[i] < 0 && y <= 0) || (m_spd[i] > 0 && y >= 464))
                    m_state[i] = 2;
            end
            m_prev[i] = a_i;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tlx%0d", i), 32'(tlx[11*i +: 11]), m_x[i] & 32'h7FF);
            chk($sformatf("tly%0d", i), 32'(tly[11*i +: 11]), (m_yf[i] >>> 6) & 32'h7FF);
            chk($sformatf("inflight%0d", i), 32'(infl[i]), 32'(m_state[i] != 0));
            chk($sformatf("reached%0d", i), 32'(rb[i]), 32'(m_state[i] == 2 && act[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s tlx%0d", tag, i), 32'(tlx[11*i +: 11]), 0);
            chk($sformatf("%s tly%0d", tag, i), 32'(tly[11*i +: 11]), 0);
        end
        chk({tag, " inflight"}, 32'(infl), 0);
        chk({tag, " reached"}, 32'(rb), 0);
    endtask

    // Drive inputs shortly after an edge, then check the combinational gate.
    task automatic drive(input bit s, input logic [2:0] a, input int x, input int y, input int sp);
        sof = s; act = a; ix = x[10:0]; iy = y[10:0]; isp = sp[10:0];
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("comb reached%0d", i), 32'(rb[i]), 32'(m_state[i] == 2 && a[i]));
    endtask

    task automatic edge_chk();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic tick(input bit s, input logic [2:0] a, input int x, input int y, input int sp);
        drive(s, a, x, y, sp);
        edge_chk();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        logic [2:0] ra;

        tbl[0] = '{1'b0, 3'b000,   0,   0,    0, 3'b000,   0,   0};
        tbl[1] = '{1'b0, 3'b001, 300, 400, -255, 3'b001, 300, 400};
        tbl[2] = '{1'b1, 3'b001,   0,   0,    0, 3'b001, 300, 396};
        tbl[3] = '{1'b0, 3'b001,   5,   5,    5, 3'b001, 300, 396};
        tbl[4] = '{1'b1, 3'b001,   0,   0,    0, 3'b001, 300, 392};

        model_reset();
        reset = 1'b1; sof = 1'b0; act = 3'b000; ix = '0; iy = '0; isp = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset held");
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            tick(tbl[v].sof, tbl[v].act, tbl[v].x, tbl[v].y, tbl[v].sp);
            chk($sformatf("vec%0d inflight", v), 32'(infl), 32'(tbl[v].e_infl));
            chk($sformatf("vec%0d tlx0", v), 32'(tlx[10:0]), tbl[v].e_tlx0);
            chk($sformatf("vec%0d tly0", v), 32'(tly[10:0]), tbl[v].e_tly0);
        end

        for (int k = 0; k < 62; k++) tick(1'b1, 3'b001, 0, 0, 0);
        chk("slot0 64 frames tly", 32'(tly[10:0]), 145);
        chk("slot0 64 frames tlx", 32'(tlx[10:0]), 300);

        tick(1'b0, 3'b011, 50, 8, -256);
        chk("slot1 launch tly", 32'(tly[21:11]), 8);
        tick(1'b1, 3'b011, 0, 0, 0);
        chk("slot1 step1 tly", 32'(tly[21:11]), 4);
        chk("slot1 step1 reached", 32'(rb), 32'(3'b000));
        tick(1'b1, 3'b011, 0, 0, 0);
        chk("slot1 step2 tly", 32'(tly[21:11]), 0);
        chk("slot1 exit reached", 32'(rb), 32'(3'b010));
        drive(1'b0, 3'b001, 0, 0, 0);
        chk("slot1 drop reached same cycle", 32'(rb[1]), 0);
        edge_chk();
        chk("slot1 drop inflight", 32'(infl[1]), 0);

        tick(1'b0, 3'b101, 20, 100, 64);
        early = 0;
        for (int k = 0; k < 363; k++) begin
            tick(1'b1, 3'b101, 0, 0, 0);
            if (rb[2]) early++;
        end
        chk("slot2 no early exit", 32'(early), 0);
        chk("slot2 363 frames tly", 32'(tly[32:22]), 463);
        tick(1'b1, 3'b101, 0, 0, 0);
        chk("slot2 exit reached", 32'(rb[2]), 1);
        chk("slot2 exit tly", 32'(tly[32:22]), 464);
        tick(1'b1, 3'b101, 0, 0, 0);
        tick(1'b1, 3'b101, 0, 0, 0);
        chk("slot2 frozen tly", 32'(tly[32:22]), 464);
        chk("slot2 frozen tlx", 32'(tlx[32:22]), 20);

        tick(1'b0, 3'b000, 0, 0, 0);
        tick(1'b1, 3'b001, 77, 200, -100);
        chk("rise with frame tly", 32'(tly[10:0]), 200);
        chk("rise with frame tlx", 32'(tlx[10:0]), 77);
        tick(1'b1, 3'b001, 0, 0, 0);
        chk("move after rise tly", 32'(tly[10:0]), 198);
        tick(1'b1, 3'b000, 0, 0, 0);
        chk("fall with frame tly", 32'(tly[10:0]), 198);
        chk("fall with frame inflight", 32'(infl[0]), 0);

        tick(1'b0, 3'b111, 10, 300, -30);
        tick(1'b1, 3'b111, 0, 0, 0);
        chk("all flying", 32'(infl), 32'(3'b111));
        act = 3'b000;
        reset = 1'b1;
        #1;
        check_zero("async reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b0, 3'b001, 300, 400, -255);
        chk("relaunch inflight", 32'(infl), 32'(3'b001));
        chk("relaunch tlx0", 32'(tlx[10:0]), 300);
        chk("relaunch tly0", 32'(tly[10:0]), 400);
        tick(1'b1, 3'b001, 0, 0, 0);
        chk("relaunch step tly0", 32'(tly[10:0]), 396);

        ra = 3'b001;
        for (int n = 0; n < 1500; n++) begin
            int sp;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 11) == 0) ra[b] = ~ra[b];
            sp = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2047)) - 1024;
            tick($urandom_range(0, 3) == 0, ra,
                 int'($urandom_range(0, 2047)) - 1024,
                 int'($urandom_range(0, 550)) - 50, sp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
